// File: rtl/nh_pixel_streamer.sv
// Purpose : reads one feature map from a synchronous pixel RAM in raster order and streams it,
//           surrounded by a PAD-pixel zero border, into the neighbourhood window engine.
// Latency : one cycle from coordinate issue to shift_in_rdy_o; first pixel two cycles after start.
// Backpressure: none downstream; out_en_i = 0 simply holds the scan position for that cycle.
//
// Ports:
//   clock_i / reset_i        single clock, synchronous active-high reset
//   start_i, base_addr_i     frame start pulse and RAM address of pixel (0,0), taken only when idle
//   out_en_i                 issue permission for the current cycle
//   mem_rd_en_o, mem_addr_o  RAM read strobe/address (address is 0 when not reading)
//   mem_rd_data_i            RAM read data, valid one cycle after mem_rd_en_o
//   shift_in_rdy_o, shift_in_o  pixel stream to the window engine
//   busy_o, frame_done_o     frame in progress / one-cycle pulse with the last pixel
module nh_pixel_streamer #(
  parameter int PIX_WIDTH = 24,
  parameter int IMG_W     = 32,
  parameter int IMG_H     = 32,
  parameter int PAD       = 1,
  parameter int ADDR_W    = 10
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic                 out_en_i,
  output logic                 mem_rd_en_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic [PIX_WIDTH-1:0] mem_rd_data_i,
  output logic                 shift_in_rdy_o,
  output logic [PIX_WIDTH-1:0] shift_in_o,
  output logic                 busy_o,
  output logic                 frame_done_o
);

  localparam int PW = IMG_W + 2 * PAD;
  localparam int PH = IMG_H + 2 * PAD;
  // One spare count value so the unsigned offset test below never aliases.
  localparam int CW = $clog2(PW + 1);
  localparam int RW = $clog2(PH + 1);

  localparam logic [CW-1:0] COL_MAX = CW'(PW - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(PH - 1);
  localparam logic [CW-1:0] COL_LO  = CW'(PAD);
  localparam logic [RW-1:0] ROW_LO  = RW'(PAD);
  localparam logic [CW-1:0] COL_N   = CW'(IMG_W);
  localparam logic [RW-1:0] ROW_N   = RW'(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  typedef struct packed {
    logic valid;
    logic pad;
    logic last;
  } tag_t;

  state_t            state_q;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  tag_t              p1_q, p1_d;

  logic          issue;
  logic          interior;
  logic          is_last;
  logic [CW-1:0] col_off;
  logic [RW-1:0] row_off;

  // Offset from the first interior column/row; coordinates left of or above the
  // interior wrap to a large unsigned value and fail the "< size" test.
  assign col_off  = col_q - COL_LO;
  assign row_off  = row_q - ROW_LO;
  assign interior = (col_off < COL_N) && (row_off < ROW_N);
  assign is_last  = (col_q == COL_MAX) && (row_q == ROW_MAX);
  assign issue    = (state_q == S_STREAM) && out_en_i;

  assign mem_rd_en_o = issue && interior;
  assign mem_addr_o  = mem_rd_en_o ? rd_ptr_q : '0;

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    rd_ptr_d = rd_ptr_q;
    p1_d     = '{valid: issue, pad: ~interior, last: is_last};
    if (state_q == S_IDLE && start_i) begin
      col_d    = '0;
      row_d    = '0;
      rd_ptr_d = base_addr_i;
    end else if (issue) begin
      if (interior) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      rd_ptr_q <= '0;
      p1_q     <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      rd_ptr_q <= rd_ptr_d;
      p1_q     <= p1_d;
      case (state_q)
        S_IDLE:   if (start_i) state_q <= S_STREAM;
        S_STREAM: if (issue && is_last) state_q <= S_DRAIN;
        S_DRAIN:  state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q != S_IDLE);
  assign shift_in_rdy_o = p1_q.valid;
  // Border pixels never touched the RAM, so the stale read data is masked here.
  assign shift_in_o     = (p1_q.valid && !p1_q.pad) ? mem_rd_data_i : '0;
  assign frame_done_o   = p1_q.valid && p1_q.last;

endmodule

// File: tb/tb_nh_pixel_streamer.sv
// Purpose : scoreboard bench for nh_pixel_streamer (4x3 PAD 1 instance and 2x2 PAD 0 instance).
// Latency : expected pixels/reads are queued at frame start and popped by a negedge monitor.
// Backpressure: out_en patterns exercised on the padded instance.
module tb_nh_pixel_streamer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        a_start, a_out_en, a_rd_en, a_rdy, a_busy, a_done;
  logic [9:0]  a_base, a_addr;
  logic [23:0] a_rd_data = '0, a_shift;
  logic        b_start, b_out_en, b_rd_en, b_rdy, b_busy, b_done;
  logic [9:0]  b_base, b_addr;
  logic [23:0] b_rd_data = '0, b_shift;

  nh_pixel_streamer #(.PIX_WIDTH(24), .IMG_W(4), .IMG_H(3), .PAD(1), .ADDR_W(10)) u_a (
    .clock_i(clock), .reset_i(reset), .start_i(a_start), .base_addr_i(a_base),
    .out_en_i(a_out_en), .mem_rd_en_o(a_rd_en), .mem_addr_o(a_addr), .mem_rd_data_i(a_rd_data),
    .shift_in_rdy_o(a_rdy), .shift_in_o(a_shift), .busy_o(a_busy), .frame_done_o(a_done));

  nh_pixel_streamer #(.PIX_WIDTH(24), .IMG_W(2), .IMG_H(2), .PAD(0), .ADDR_W(10)) u_b (
    .clock_i(clock), .reset_i(reset), .start_i(b_start), .base_addr_i(b_base),
    .out_en_i(b_out_en), .mem_rd_en_o(b_rd_en), .mem_addr_o(b_addr), .mem_rd_data_i(b_rd_data),
    .shift_in_rdy_o(b_rdy), .shift_in_o(b_shift), .busy_o(b_busy), .frame_done_o(b_done));

  int n_checks = 0;
  int n_pass   = 0;
  int pix_a    = 0;

  logic [24:0] exp_a[$], exp_b[$];  // {last, pixel}
  logic [9:0]  rd_a[$], rd_b[$];
  logic [24:0] ea, eb;
  logic        a_done_prev = 1'b0, b_done_prev = 1'b0;

  function automatic logic [23:0] ram_val(input logic [9:0] a);
    return {4'hA, a, ~a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic fail(input string nm);
    n_checks++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Synchronous RAM models.
  always @(posedge clock) begin
    if (a_rd_en) a_rd_data <= ram_val(a_addr);
    if (b_rd_en) b_rd_data <= ram_val(b_addr);
  end

  // Monitor: pops the scoreboard whenever a DUT presents a pixel or a read.
  always @(negedge clock) begin
    if (a_rdy === 1'b1) begin
      if (exp_a.size() == 0) fail("extra_pixel_a");
      else begin
        ea = exp_a.pop_front();
        chk("pixel_a", 32'(a_shift), 32'(ea[23:0]));
        chk("frame_done_a", 32'(a_done), 32'(ea[24]));
      end
      pix_a++;
    end else begin
      chk("idle_out_a", 32'({a_done, a_shift}), 32'd0);
    end
    if (a_done_prev) chk("busy_drop_a", 32'(a_busy), 32'd0);
    a_done_prev = (a_done === 1'b1);
    if (a_rd_en === 1'b1) begin
      if (rd_a.size() == 0) fail("extra_read_a");
      else chk("rd_addr_a", 32'(a_addr), 32'(rd_a.pop_front()));
    end else begin
      chk("addr_zero_a", 32'(a_addr), 32'd0);
    end

    if (b_rdy === 1'b1) begin
      if (exp_b.size() == 0) fail("extra_pixel_b");
      else begin
        eb = exp_b.pop_front();
        chk("pixel_b", 32'(b_shift), 32'(eb[23:0]));
        chk("frame_done_b", 32'(b_done), 32'(eb[24]));
      end
    end else begin
      chk("idle_out_b", 32'({b_done, b_shift}), 32'd0);
    end
    if (b_done_prev) chk("busy_drop_b", 32'(b_busy), 32'd0);
    b_done_prev = (b_done === 1'b1);
    if (b_rd_en === 1'b1) begin
      if (rd_b.size() == 0) fail("extra_read_b");
      else chk("rd_addr_b", 32'(b_addr), 32'(rd_b.pop_front()));
    end else begin
      chk("addr_zero_b", 32'(b_addr), 32'd0);
    end
  end

  // Modes: 0 out_en=1, 1 out_en 1,0,0..., 2 start re-pulsed at pixel 10,
  // 3 reset at pixel 7, 4 start pulsed in the frame_done cycle.
  task automatic run_a(input logic [9:0] base, input int mode);
    int  cyc;
    int  ev;
    bit  first;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 6; c++) begin
        bit inter;
        bit last;
        logic [9:0] ad;
        inter = (r >= 1 && r <= 3 && c >= 1 && c <= 4);
        last  = (r == 4 && c == 5);
        ad    = base + 10'((r - 1) * 4 + (c - 1));
        exp_a.push_back({last, inter ? ram_val(ad) : 24'd0});
        if (inter) rd_a.push_back(ad);
      end
    end
    pix_a    = 0;
    ev       = 0;
    first    = 0;
    a_base   = base;
    a_start  = 1'b1;
    a_out_en = 1'b1;
    @(posedge clock); #1;
    cyc = 1;
    while (1) begin
      a_start = 1'b0;
      if (!first && a_rdy) begin
        first = 1;
        chk("first_latency_a", 32'(cyc), 32'd2);
      end
      if (ev == 1) begin
        chk("busy_hold_a", 32'(a_busy), 32'd1);
        ev = 2;
      end
      if (cyc > 2 && !a_busy) break;
      if (cyc >= 400) begin
        fail("timeout_a");
        break;
      end
      a_out_en = (mode == 1) ? ((cyc - 1) % 3 == 0) : 1'b1;
      if (mode == 2 && ev == 0 && pix_a == 10) begin
        ev      = 1;
        a_start = 1'b1;
        a_base  = 10'h100;
      end
      if (mode == 4 && a_done) a_start = 1'b1;
      if (mode == 3 && pix_a == 7) begin
        reset = 1'b1;
        @(posedge clock); #1;
        exp_a.delete();
        rd_a.delete();
        chk("rst_busy_a", 32'(a_busy), 32'd0);
        chk("rst_rdy_a", 32'(a_rdy), 32'd0);
        chk("rst_rd_en_a", 32'(a_rd_en), 32'd0);
        chk("rst_done_a", 32'(a_done), 32'd0);
        reset    = 1'b0;
        a_out_en = 1'b1;
        return;
      end
      @(posedge clock); #1;
      cyc++;
    end
    a_start  = 1'b0;
    a_out_en = 1'b1;
    chk("pixel_count_a", 32'(pix_a), 32'd30);
    chk("queue_empty_a", 32'(exp_a.size() + rd_a.size()), 32'd0);
    if (mode == 4) begin
      @(posedge clock); #1;
      chk("restart_ignored_a", 32'(a_busy), 32'd0);
    end
  endtask

  task automatic run_b();
    for (int i = 0; i < 4; i++) begin
      exp_b.push_back({(i == 3), ram_val(10'h3FC + 10'(i))});
      rd_b.push_back(10'h3FC + 10'(i));
    end
    b_base   = 10'h3FC;
    b_out_en = 1'b1;
    b_start  = 1'b1;
    @(posedge clock); #1;
    b_start = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      chk("rdy_b", 32'(b_rdy), 32'(cyc >= 2 && cyc <= 5));
      chk("busy_b", 32'(b_busy), 32'(cyc <= 5));
      @(posedge clock); #1;
    end
    chk("queue_empty_b", 32'(exp_b.size() + rd_b.size()), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    a_start  = 1'b0; a_out_en = 1'b0; a_base = '0;
    b_start  = 1'b0; b_out_en = 1'b0; b_base = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 32'(a_busy), 32'd0);
    chk("reset_rdy", 32'(a_rdy), 32'd0);
    chk("reset_rd_en", 32'(a_rd_en), 32'd0);
    chk("reset_shift_in", 32'(a_shift), 32'd0);
    chk("reset_frame_done", 32'(a_done), 32'd0);
    chk("reset_addr", 32'(a_addr), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_a(10'h010, 0);
    run_a(10'h010, 1);
    run_a(10'h010, 2);
    run_a(10'h010, 3);
    run_a(10'h010, 0);
    run_a(10'h010, 4);
    run_a(10'h010, 0);
    run_a(10'h010, 0);
    run_b();

    repeat (3) @(posedge clock);
    #1;
    chk("final_idle_a", 32'(a_busy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
